// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-side memory access controller.
// Holds the access-size encodings, the data width and the response
// buffer state type. The load alignment unit uses this package too,
// so it can be reused by the fetch path without pulling in the controller.
package mem_access_ctrl_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } resp_state_e;

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// load_align: purely combinational load-data formatter.
// It selects the addressed byte or halfword lane from a 32-bit RAM word
// and sign- or zero-extends it to 32 bits.
// Ports:
//   ram_rdata     in  32  raw word read from the RAM
//   addr          in  2   low byte-address bits (lane select)
//   size          in  2   access size (byte/half/word; 11 gives 0)
//   load_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   result        out 32  aligned, extended load data
module load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [1:0]        addr,
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_lane_s;
    logic [15:0] half_lane_s;
    logic        byte_ext_s;
    logic        half_ext_s;

    // Lane selection: byte lane by addr[1:0], halfword lane by addr[1].
    always_comb begin
        byte_lane_s = 8'h00;
        half_lane_s = 16'h0000;
        case (addr)
            2'b00:   byte_lane_s = ram_rdata[7:0];
            2'b01:   byte_lane_s = ram_rdata[15:8];
            2'b10:   byte_lane_s = ram_rdata[23:16];
            2'b11:   byte_lane_s = ram_rdata[31:24];
            default: byte_lane_s = 8'h00;
        endcase
        if (addr[1]) begin
            half_lane_s = ram_rdata[31:16];
        end else begin
            half_lane_s = ram_rdata[15:0];
        end
    end

    // Extension: the fill bit is the lane's MSB for signed loads, zero otherwise.
    always_comb begin
        byte_ext_s = (~load_unsigned) & byte_lane_s[7];
        half_ext_s = (~load_unsigned) & half_lane_s[15];
        result     = 32'h0000_0000;
        case (size)
            SZ_BYTE: result = {{24{byte_ext_s}}, byte_lane_s};
            SZ_HALF: result = {{16{half_ext_s}}, half_lane_s};
            SZ_WORD: result = ram_rdata;
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte-addressed load/store front end for a 1024x32 RAM
// with byte write enables and asynchronous read.
// One request per cycle over valid/ready. The RAM port is driven
// combinationally in the accept cycle. Each request's result is returned
// through a registered one-entry response buffer.
// Ports:
//   clk, resetn                  clock, async active-low reset
//   req_valid/req_ready          request handshake
//   req_wr, req_size, req_unsigned, req_addr, req_wdata   request fields
//   resp_valid/resp_ready        response handshake
//   resp_rdata, resp_err         registered response payload
//   ram_en, ram_wen, ram_addr, ram_wdata, ram_rdata       RAM port
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int RAM_AW = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    resp_state_e       state_r;
    resp_state_e       state_nxt_s;
    logic              fire_s;
    logic              err_s;
    logic [DATA_W-1:0] load_data_s;
    logic [DATA_W-1:0] rdata_nxt_s;
    logic [DATA_W-1:0] resp_rdata_r;
    logic              resp_err_r;

    load_align u_load_align (
        .ram_rdata     (ram_rdata),
        .addr          (req_addr[1:0]),
        .size          (req_size),
        .load_unsigned (req_unsigned),
        .result        (load_data_s)
    );

    // The buffer can take a new response when it is empty or is being drained.
    assign resp_valid = (state_r == ST_FULL);
    assign req_ready  = (~resp_valid) | resp_ready;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

    // Acceptance and alignment check. Gating with resetn keeps the RAM
    // untouched while reset is held.
    always_comb begin
        fire_s = req_valid & req_ready & resetn;
        err_s  = 1'b0;
        case (req_size)
            SZ_BYTE: err_s = 1'b0;
            SZ_HALF: err_s = req_addr[0];
            SZ_WORD: err_s = (req_addr[1:0] != 2'b00);
            default: err_s = 1'b1;
        endcase
    end

    // RAM port drive: byte enables are shifted into the addressed lanes,
    // and write data is replicated so every lane carries the right bytes.
    always_comb begin
        ram_addr  = req_addr[ADDR_W-1:2];
        ram_en    = fire_s & (~err_s);
        ram_wen   = 4'b0000;
        ram_wdata = req_wdata;
        case (req_size)
            SZ_BYTE: ram_wdata = {4{req_wdata[7:0]}};
            SZ_HALF: ram_wdata = {2{req_wdata[15:0]}};
            default: ram_wdata = req_wdata;
        endcase
        if (ram_en && req_wr) begin
            case (req_size)
                SZ_BYTE: ram_wen = 4'b0001 << req_addr[1:0];
                SZ_HALF: ram_wen = 4'b0011 << req_addr[1:0];
                SZ_WORD: ram_wen = 4'b1111;
                default: ram_wen = 4'b0000;
            endcase
        end else begin
            ram_wen = 4'b0000;
        end
    end

    // Response buffer next state and the payload to capture on accept.
    always_comb begin
        state_nxt_s = state_r;
        if (!req_wr && !err_s) begin
            rdata_nxt_s = load_data_s;
        end else begin
            rdata_nxt_s = 32'h0000_0000;
        end
        case (state_r)
            ST_EMPTY: begin
                if (fire_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (resp_ready && !fire_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // Response buffer registers. The payload is only reloaded on accept,
    // so it holds steady while the consumer stalls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_EMPTY;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (fire_s) begin
                resp_rdata_r <= rdata_nxt_s;
                resp_err_r   <= err_s;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a behavioural
// 1024x32 byte-enable RAM that is read asynchronously.
module tb_mem_access_ctrl;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:1023];
    logic        clr_mem;
    int          n_cmp;
    int          n_fail;

    mem_access_ctrl #(.ADDR_W(12), .RAM_AW(10)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_en       (ram_en),
        .ram_wen      (ram_wen),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: byte-enable write on the rising edge, async read.
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end
    assign ram_rdata = mem[ram_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Apply a request at the falling edge; outputs settle 1 time unit later.
    task automatic drive(input logic v, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [11:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = v; req_wr = wr; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        #1;
    endtask

    // Issue a load and check the registered response one cycle later.
    task automatic load_chk(input string tag, input logic [1:0] sz, input logic uns,
                            input logic [11:0] a, input logic [31:0] exp, input logic exp_err);
        drive(1'b1, 1'b0, sz, uns, a, 32'h0);
        chk({tag, "_wen"}, {28'h0, ram_wen}, 32'h0);
        chk({tag, "_en"}, {31'h0, ram_en}, {31'h0, ~exp_err});
        @(negedge clk);
        chk({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
        chk({tag, "_rdata"}, resp_rdata, exp);
        chk({tag, "_err"}, {31'h0, resp_err}, {31'h0, exp_err});
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        resetn = 1'b0; clr_mem = 1'b1; resp_ready = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 12'h0; req_wdata = 32'h0;
        @(negedge clk);
        clr_mem = 1'b0;
        // Store attempted while reset is held must not reach the RAM
        drive(1'b1, 1'b1, 2'b10, 1'b0, 12'h040, 32'hFFFF_FFFF);
        chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
        chk("rst_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'h0, resp_err}, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        resetn = 1'b1;

        // Word store then load of the same word
        drive(1'b1, 1'b1, 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF);
        chk("sw_wen", {28'h0, ram_wen}, 32'hF);
        chk("sw_addr", {22'h0, ram_addr}, 32'h004);
        chk("sw_wdata", ram_wdata, 32'hDEAD_BEEF);
        chk("sw_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        chk("sw_valid", {31'h0, resp_valid}, 32'h1);
        chk("sw_rdata", resp_rdata, 32'h0);
        load_chk("lw10", 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF, 1'b0);

        // Byte store into the top lane, then signed/unsigned reads
        drive(1'b1, 1'b1, 2'b00, 1'b0, 12'h013, 32'h1234_5680);
        chk("sb_wen", {28'h0, ram_wen}, 32'h8);
        chk("sb_wdata", ram_wdata, 32'h8080_8080);
        load_chk("lb13", 2'b00, 1'b0, 12'h013, 32'hFFFF_FF80, 1'b0);
        load_chk("lbu13", 2'b00, 1'b1, 12'h013, 32'h0000_0080, 1'b0);
        load_chk("lw10b", 2'b10, 1'b0, 12'h010, 32'h80AD_BEEF, 1'b0);
        load_chk("lb12", 2'b00, 1'b0, 12'h012, 32'hFFFF_FFAD, 1'b0);
        load_chk("lbu10", 2'b00, 1'b1, 12'h010, 32'h0000_00EF, 1'b0);

        // Halfword store in upper lane, loads and a misaligned half
        drive(1'b1, 1'b1, 2'b01, 1'b0, 12'h022, 32'hABCD_1234);
        chk("sh_wen", {28'h0, ram_wen}, 32'hC);
        chk("sh_wdata", ram_wdata, 32'h1234_1234);
        load_chk("lh22", 2'b01, 1'b0, 12'h022, 32'h0000_1234, 1'b0);
        load_chk("lh21", 2'b01, 1'b0, 12'h021, 32'h0, 1'b1);
        load_chk("lh10", 2'b01, 1'b0, 12'h010, 32'hFFFF_BEEF, 1'b0);
        load_chk("lhu12", 2'b01, 1'b1, 12'h012, 32'h0000_80AD, 1'b0);
        load_chk("lw32", 2'b10, 1'b0, 12'h032, 32'h0, 1'b1);

        // Back-pressure: consumer stalls with a store waiting
        drive(1'b1, 1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
        @(negedge clk);
        resp_ready = 1'b0;
        req_wr = 1'b1; req_addr = 12'h030; req_wdata = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", {31'h0, req_ready}, 32'h0);
            chk("bp_wen", {28'h0, ram_wen}, 32'h0);
            chk("bp_valid", {31'h0, resp_valid}, 32'h1);
            chk("bp_rdata", resp_rdata, 32'h80AD_BEEF);
            @(negedge clk);
        end
        chk("bp_mem_hold", mem[12], 32'h0);
        resp_ready = 1'b1;
        #1;
        chk("bp_rel_ready", {31'h0, req_ready}, 32'h1);
        chk("bp_rel_wen", {28'h0, ram_wen}, 32'hF);
        @(negedge clk);
        chk("bp_st_rdata", resp_rdata, 32'h0);
        chk("bp_st_err", {31'h0, resp_err}, 32'h0);
        load_chk("lw30", 2'b10, 1'b0, 12'h030, 32'h5555_5555, 1'b0);

        // Illegal size store is consumed with an error and no write
        drive(1'b1, 1'b1, 2'b11, 1'b0, 12'h040, 32'hCAFE_F00D);
        chk("ill_ready", {31'h0, req_ready}, 32'h1);
        chk("ill_en", {31'h0, ram_en}, 32'h0);
        chk("ill_wen", {28'h0, ram_wen}, 32'h0);
        @(negedge clk);
        chk("ill_valid", {31'h0, resp_valid}, 32'h1);
        chk("ill_err", {31'h0, resp_err}, 32'h1);
        chk("ill_rdata", resp_rdata, 32'h0);
        load_chk("lw40", 2'b10, 1'b0, 12'h040, 32'h0, 1'b0);

        // Asynchronous reset with a FULL buffer
        drive(1'b1, 1'b0, 2'b10, 1'b0, 12'h030, 32'h0);
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b0;
        chk("pre_rst_valid", {31'h0, resp_valid}, 32'h1);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_valid", {31'h0, resp_valid}, 32'h0);
        chk("async_rst_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1; resp_ready = 1'b1;
        load_chk("post_rst_lw30", 2'b10, 1'b0, 12'h030, 32'h5555_5555, 1'b0);

        // Drain with no new request: buffer empties
        drive(1'b0, 1'b0, 2'b00, 1'b0, 12'h000, 32'h0);
        @(negedge clk);
        chk("drain_valid", {31'h0, resp_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Byte-addressed load/store front end that sits directly upstream of the 1024x32 word RAM with byte write enables and asynchronous read.
- Accepts one request per cycle over a valid/ready handshake and checks alignment.
- Drives RAM en/wen/addr/wdata. For loads, extracts and sign/zero-extends the addressed byte, halfword or word.
- Returns every request's result through a registered one-entry response buffer with valid/ready back-pressure.

Parameters:
ADDR_W, 12, byte-address width; RAM word address = req_addr[ADDR_W-1:2]
RAM_AW, 10, RAM word-address width (ADDR_W-2)

Ports:
clk  in  1  clock, all state updates on rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_wr  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  response present
resp_ready  in  1  response consumed when resp_valid && resp_ready
resp_rdata  out  32  load result; 0 for stores and errors
resp_err  out  1  misaligned or illegal-size request
ram_en  out  1  RAM access enable
ram_wen  out  4  RAM byte write enables
ram_addr  out  RAM_AW  RAM word address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM asynchronous read data

Behaviour:
- Reset (resetn=0, asynchronous): resp_valid=0, resp_rdata=0, resp_err=0. No RAM write occurs while reset is asserted. Any buffered response is dropped.
- req_ready = !resp_valid || resp_ready. This allows full throughput of one request per cycle when the consumer is always ready.
- fire = req_valid && req_ready.
- Error conditions: err = (size==11) || (size==01 && addr[0]) || (size==10 && addr[1:0]!=0).
- RAM interface, combinational:
  - ram_addr = req_addr[ADDR_W-1:2].
  - ram_en = fire && !err.
  - ram_wen = 0 unless ram_en && req_wr. Then: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011<<addr[1:0]; word -> 4'b1111.
  - ram_wdata replicates the data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load data, combinational in the fire cycle, taken from ram_rdata:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Extend to 32 bits per req_unsigned.
- Response buffer, two-state FSM EMPTY/FULL:
  - EMPTY --fire--> FULL.
  - FULL & resp_ready & !fire --> EMPTY.
  - FULL & resp_ready & fire --> FULL, reloaded with the new response.
  - FULL & !resp_ready --> FULL. Outputs hold stable and req_ready=0.
- On fire, the registered values are:
  - resp_err = err.
  - resp_rdata = extended load data if (!req_wr && !err), else 0.
- Latency: response is valid the cycle after acceptance. A store's RAM write happens at the same edge the response is registered.
- Store then load to the same word in consecutive cycles: the load returns the new data, because the RAM is written at the edge and read asynchronously afterward. No forwarding logic is needed.
- Errored requests are consumed, issue no RAM access (ram_en=0), and return resp_err=1.
- req_* inputs are don't-care when req_valid=0. Outputs never depend on resp_ready except through req_ready.
- Reset asserted mid-operation clears FULL immediately. The first request after deassertion behaves as from EMPTY.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - the 32-bit data width constant.
- Sub-module load_align: purely combinational lane select plus sign/zero extension. Inputs: ram_rdata, addr[1:0], size, unsigned. Output: 32-bit result. It is reused later by the instruction-side fetch path.
- Handshake FSM, wen/wdata generation and error check stay in mem_access_ctrl.

Test Plan:
- Store word 0xDEADBEEF @0x010, then load word @0x010, resp_ready=1 -> ram_wen=1111 / ram_addr=0x004 on the store; load resp_rdata=0xDEADBEEF, resp_err=0 one cycle after acceptance.
- Store byte 0x80 @0x013, then lb @0x013 and lbu @0x013 -> wen=1000, wdata=0x80808080; lb returns 0xFFFFFF80, lbu returns 0x00000080, other bytes unchanged.
- Half store 0x1234 @0x022, then load half signed @0x022 -> wen=1100, resp_rdata=0x00001234. Load half @0x021 -> resp_err=1, rdata=0, ram_en=0.
- Hold resp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, response outputs stable, no RAM write. Raise resp_ready -> the queued request is accepted that cycle, back-to-back.
- req_size=11 store -> consumed, resp_err=1, ram_wen=0, RAM contents unchanged.
- Assert resetn=0 while a response is FULL -> resp_valid drops immediately without waiting for clk. After release, the next request completes with normal latency.
